data_memory_responder: RTL and testbench

//   Responder side of the pipeline's data-memory interface: serves loads/stores issued from the MEM stage and

---
 rtl/data_memory_responder.sv | 162 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-memory responder: byte-addressed little-endian RAM behind a fixed-latency
// request/BUSY_WAIT handshake, with load extension and store byte-lane masking.
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [2:0]            MEM_READ,
  input  logic [2:0]            MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic                  BUSY_WAIT,
  output logic [31:0]           READ_DATA,
  output logic                  MISALIGNED
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned WORDS = 2 ** IDX_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  store_q;
  size_t                 size_q;
  logic                  unsigned_q;
  logic                  mis_pend_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem_q [WORDS];

  logic       rd_valid_c, wr_valid_c, req_c, req_mis_c, req_uns_c, last_c, commit_c;
  size_t      req_size_c;
  logic [IDX_W-1:0] widx_c;
  logic [1:0] lane_c;
  logic [31:0] word_c, load_c, wrep_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [3:0]  be_c;

  // Request decode; a valid store wins over a simultaneous load.
  assign rd_valid_c = (MEM_READ != 3'd0) && (MEM_READ <= 3'd5);
  assign wr_valid_c = (MEM_WRITE != 3'd0) && !MEM_WRITE[2];
  assign req_c      = rd_valid_c || wr_valid_c;

  always_comb begin
    req_size_c = SZ_BYTE;
    req_uns_c  = 1'b0;
    if (wr_valid_c) begin
      case (MEM_WRITE[1:0])
        2'd1:    req_size_c = SZ_BYTE;
        2'd2:    req_size_c = SZ_HALF;
        default: req_size_c = SZ_WORD;
      endcase
    end else begin
      case (MEM_READ)
        3'd1: req_size_c = SZ_BYTE;
        3'd2: req_size_c = SZ_HALF;
        3'd3: req_size_c = SZ_WORD;
        3'd4: begin req_size_c = SZ_BYTE; req_uns_c = 1'b1; end
        3'd5: begin req_size_c = SZ_HALF; req_uns_c = 1'b1; end
        default: req_size_c = SZ_BYTE;
      endcase
    end
  end

  assign req_mis_c = ((req_size_c == SZ_HALF) && ADDRESS[0]) ||
                     ((req_size_c == SZ_WORD) && (ADDRESS[1:0] != 2'b00));

  // Stall in the request cycle itself so the pipeline never advances past it.
  assign BUSY_WAIT = (state_q == S_IDLE) ? req_c : (state_q == S_ACCESS);

  // The request cycle counts toward LATENCY, so ACCESS ends one count early.
  assign last_c   = (cnt_q <= CNT_W'(1));
  assign commit_c = RESET && (state_q == S_ACCESS) && last_c && store_q;

  // Lane selection on the aligned word.
  assign widx_c = addr_q[ADDR_WIDTH-1:2];
  assign lane_c = addr_q[1:0];
  assign word_c = mem_q[widx_c];
  assign byte_c = word_c[{lane_c, 3'b000} +: 8];
  assign half_c = word_c[{lane_c[1], 4'b0000} +: 16];

  always_comb begin
    load_c = word_c;
    wrep_c = wdata_q;
    be_c   = 4'b1111;
    case (size_q)
      SZ_BYTE: begin
        load_c = unsigned_q ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
        wrep_c = {4{wdata_q[7:0]}};
        be_c   = 4'b0001 << lane_c;
      end
      SZ_HALF: begin
        load_c = unsigned_q ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
        wrep_c = {2{wdata_q[15:0]}};
        be_c   = lane_c[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_c = word_c;
        wrep_c = wdata_q;
        be_c   = 4'b1111;
      end
    endcase
  end

  // RAM array is never reset; writes only on a completed, non-aborted store.
  always_ff @(posedge CLK) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[widx_c][8*i +: 8] <= wrep_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      store_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      mis_pend_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      READ_DATA  <= '0;
      MISALIGNED <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_c) begin
            store_q    <= wr_valid_c;
            size_q     <= req_size_c;
            unsigned_q <= req_uns_c;
            mis_pend_q <= req_mis_c;
            addr_q     <= ADDRESS;
            wdata_q    <= WRITE_DATA;
            cnt_q      <= CNT_W'(LATENCY - 1);
            MISALIGNED <= 1'b0;
            state_q    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (last_c) begin
            READ_DATA  <= store_q ? 32'd0 : load_c;
            MISALIGNED <= mis_pend_q;
            cnt_q      <= '0;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: latency, load extension, store masking,
// write priority, reset abort and back-to-back handshake.
module tb_data_memory_responder;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [2:0]  MEM_READ = 3'd0;
  logic [2:0]  MEM_WRITE = 3'd0;
  logic [9:0]  ADDRESS = 10'd0;
  logic [31:0] WRITE_DATA = 32'd0;
  logic        BUSY_WAIT;
  logic [31:0] READ_DATA;
  logic        MISALIGNED;

  int checks = 0;
  int passes = 0;

  data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .BUSY_WAIT(BUSY_WAIT),
    .READ_DATA(READ_DATA), .MISALIGNED(MISALIGNED)
  );

  always #5 CLK = ~CLK;

  // Issue one request, hold it through the stall, capture outputs in the DONE cycle.
  task automatic do_access(input logic [2:0] rd, input logic [2:0] wr, input logic [9:0] addr,
                           input logic [31:0] wd, output int busy, output logic [31:0] rdata,
                           output logic mis);
    @(negedge CLK);
    MEM_READ = rd; MEM_WRITE = wr; ADDRESS = addr; WRITE_DATA = wd;
    #1;
    busy = 0;
    while (BUSY_WAIT === 1'b1 && busy < 50) begin
      busy++;
      @(negedge CLK);
      #1;
    end
    rdata = READ_DATA;
    mis   = MISALIGNED;
    MEM_READ = 3'd0; MEM_WRITE = 3'd0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) RESET = 1'b1;
      @(negedge CLK);
      #1;
      checks++;
      if (BUSY_WAIT !== 1'b0 || READ_DATA !== 32'd0 || MISALIGNED !== 1'b0)
        $display("FAIL reset_idle c%0d: busy=%b rd=%h mis=%b, want 0/0/0", c, BUSY_WAIT, READ_DATA, MISALIGNED);
      else passes++;
    end
  endtask

  task automatic test_word();
    int b; logic [31:0] d; logic m;
    do_access(3'd0, 3'd3, 10'h010, 32'hDEADBEEF, b, d, m);
    checks++; if (b !== 4) $display("FAIL sw_busy: got %0d want 4", b); else passes++;
    checks++; if (d !== 32'd0) $display("FAIL sw_rdata: got %h want 00000000", d); else passes++;
    do_access(3'd3, 3'd0, 10'h010, 32'h0, b, d, m);
    checks++; if (b !== 4) $display("FAIL lw_busy: got %0d want 4", b); else passes++;
    checks++; if (d !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", d); else passes++;
    checks++; if (m !== 1'b0) $display("FAIL lw_mis: got %b want 0", m); else passes++;
  endtask

  task automatic test_extension();
    logic [2:0]  op  [4] = '{3'd1, 3'd4, 3'd2, 3'd5};
    logic [9:0]  ad  [4] = '{10'h013, 10'h013, 10'h010, 10'h012};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    int b; logic [31:0] d; logic m;
    for (int i = 0; i < 4; i++) begin
      do_access(op[i], 3'd0, ad[i], 32'h0, b, d, m);
      checks++;
      if (d !== exp[i]) $display("FAIL load_ext%0d: got %h want %h", i, d, exp[i]); else passes++;
    end
  endtask

  task automatic test_store_mask();
    int b; logic [31:0] d; logic m;
    do_access(3'd0, 3'd1, 10'h011, 32'h12345677, b, d, m);
    do_access(3'd3, 3'd0, 10'h010, 32'h0, b, d, m);
    checks++; if (d !== 32'hDEAD77EF) $display("FAIL sb_merge: got %h want dead77ef", d); else passes++;
    do_access(3'd0, 3'd2, 10'h013, 32'h0000A55A, b, d, m);
    checks++; if (m !== 1'b1) $display("FAIL sh_mis: got %b want 1", m); else passes++;
    do_access(3'd3, 3'd0, 10'h010, 32'h0, b, d, m);
    checks++; if (d !== 32'hA55A77EF) $display("FAIL sh_merge: got %h want a55a77ef", d); else passes++;
    checks++; if (m !== 1'b0) $display("FAIL mis_clear: got %b want 0", m); else passes++;
    do_access(3'd3, 3'd0, 10'h012, 32'h0, b, d, m);
    checks++; if (d !== 32'hA55A77EF || m !== 1'b1)
      $display("FAIL lw_misaligned: got %h/%b want a55a77ef/1", d, m); else passes++;
  endtask

  task automatic test_write_priority();
    int b; logic [31:0] d; logic m;
    do_access(3'd3, 3'd3, 10'h020, 32'h0000CAFE, b, d, m);
    checks++; if (d !== 32'd0) $display("FAIL both_rdata: got %h want 00000000", d); else passes++;
    do_access(3'd3, 3'd0, 10'h020, 32'h0, b, d, m);
    checks++; if (d !== 32'h0000CAFE) $display("FAIL both_write: got %h want 0000cafe", d); else passes++;
  endtask

  task automatic test_reset_abort();
    int b; logic [31:0] d; logic m;
    do_access(3'd0, 3'd3, 10'h030, 32'h22222222, b, d, m);
    @(negedge CLK);
    MEM_WRITE = 3'd3; ADDRESS = 10'h030; WRITE_DATA = 32'h11111111;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0; MEM_WRITE = 3'd0;
    @(negedge CLK);
    #1;
    checks++; if (BUSY_WAIT !== 1'b0 || READ_DATA !== 32'd0)
      $display("FAIL abort_busy: got %b/%h want 0/00000000", BUSY_WAIT, READ_DATA); else passes++;
    RESET = 1'b1;
    do_access(3'd3, 3'd0, 10'h030, 32'h0, b, d, m);
    checks++; if (d !== 32'h22222222) $display("FAIL abort_nocommit: got %h want 22222222", d); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] pat = '0;
    @(negedge CLK);
    MEM_READ = 3'd3; ADDRESS = 10'h010;
    for (int c = 0; c < 10; c++) begin
      #1;
      pat = {pat[8:0], BUSY_WAIT};
      @(negedge CLK);
    end
    MEM_READ = 3'd0;
    checks++; if (pat !== 10'b1111011110) $display("FAIL b2b_pattern: got %b want 1111011110", pat); else passes++;
    checks++; if (READ_DATA !== 32'hA55A77EF) $display("FAIL b2b_data: got %h want a55a77ef", READ_DATA); else passes++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_extension();
    test_store_mask();
    test_write_priority();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
